// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the two-port memory bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    localparam logic CPU_PORT  = 1'b0;
    localparam logic LOAD_PORT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == LOAD_PORT) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin winner select with a registered priority pointer.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_grant,
    output logic       o_valid,
    output logic       o_winner
);

    logic r_prio;

    always_comb begin
        o_valid  = |i_req;
        o_winner = CPU_PORT;
        case (i_req)
            2'b01:   o_winner = CPU_PORT;
            2'b10:   o_winner = LOAD_PORT;
            2'b11:   o_winner = r_prio;
            default: o_winner = CPU_PORT;
        endcase
    end

    // After any grant the other port becomes the favoured one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio <= CPU_PORT;
        end else if (i_grant && o_valid) begin
            r_prio <= ~o_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one memory port between the CPU and the loader port.
// Rev     : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] adr_bus,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [DATA_W-1:0] data_bus_out,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_owner;
    logic              r_wr;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_valid;
    logic              w_winner;
    logic              w_grant;
    logic              w_access_end;

    assign w_grant      = (r_state == ST_IDLE) && w_valid;
    assign w_access_end = (r_state == ST_ACCESS) && (r_wait_cnt == '0);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_req    (req),
        .i_grant  (w_grant),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
            ST_ACCESS: if (r_wait_cnt == '0) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Address, direction and write data are frozen at grant so requesters
    // may change their inputs freely while the access is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_owner    <= CPU_PORT;
            r_wr       <= 1'b0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_winner;
                r_wr       <= wr[w_winner];
                r_adr      <= (w_winner == LOAD_PORT) ? adr1 : adr0;
                r_wdata    <= (w_winner == LOAD_PORT) ? wdata1 : wdata0;
                r_wait_cnt <= CNT_W'(WAIT_CYCLES);
            end else if ((r_state == ST_ACCESS) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
            if (w_access_end && !r_wr) begin
                r_rdata <= data_bus_in;
            end
        end
    end

    assign rd_mem       = (r_state == ST_ACCESS) && !r_wr;
    assign wr_mem       = (r_state == ST_ACCESS) &&  r_wr;
    assign gnt          = (r_state != ST_IDLE) ? port_onehot(r_owner) : 2'b00;
    assign ack          = (r_state == ST_DONE) ? port_onehot(r_owner) : 2'b00;
    assign busy         = (r_state != ST_IDLE);
    assign adr_bus      = r_adr;
    assign data_bus_out = r_wdata;
    assign rdata        = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed self-checking bench for mem_bus_arbiter (W=1 and W=0).
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;

    logic [1:0] req, wr;
    logic [5:0] adr0, adr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, ack;
    logic [7:0] rdata;
    logic [5:0] adr_bus;
    logic       rd_mem, wr_mem, busy;
    logic [7:0] data_bus_out, data_bus_in;

    logic [1:0] req_z, wr_z;
    logic [5:0] adr0_z, adr1_z;
    logic [7:0] wdata0_z, wdata1_z;
    logic [1:0] gnt_z, ack_z;
    logic [7:0] rdata_z;
    logic [5:0] adr_bus_z;
    logic       rd_mem_z, wr_mem_z, busy_z;
    logic [7:0] data_bus_out_z, data_bus_in_z;

    logic [7:0] mem [64];

    int n_cmp  = 0;
    int n_err  = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr),
        .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .rdata(rdata), .adr_bus(adr_bus),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .data_bus_out(data_bus_out),
        .data_bus_in(data_bus_in), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .req(req_z), .wr(wr_z),
        .adr0(adr0_z), .adr1(adr1_z), .wdata0(wdata0_z), .wdata1(wdata1_z),
        .gnt(gnt_z), .ack(ack_z), .rdata(rdata_z), .adr_bus(adr_bus_z),
        .rd_mem(rd_mem_z), .wr_mem(wr_mem_z), .data_bus_out(data_bus_out_z),
        .data_bus_in(data_bus_in_z), .busy(busy_z)
    );

    // Memory models: a writable array for the main DUT, a fixed ROM for dut_z.
    always @(posedge clk) if (wr_mem) mem[adr_bus] <= data_bus_out;
    assign data_bus_in   = mem[adr_bus];
    assign data_bus_in_z = (adr_bus_z == 6'h3F) ? 8'h9C : 8'h00;

    always @(negedge clk) if (gnt === 2'b11) n_both++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        logic [1:0] exp_ack;

        reset  = 1'b0;
        req    = 2'b11;   wr     = 2'b01;
        adr0   = 6'h05;   adr1   = 6'h05;
        wdata0 = 8'hA5;   wdata1 = 8'h00;
        req_z  = 2'b00;   wr_z   = 2'b00;
        adr0_z = 6'h3F;   adr1_z = 6'h00;
        wdata0_z = 8'h00; wdata1_z = 8'h00;

        // Reset held two edges with both ports requesting.
        tick(); tick();
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_ack",   32'(ack), 32'h0);
        chk("rst_rd",    32'(rd_mem), 32'h0);
        chk("rst_wr",    32'(wr_mem), 32'h0);
        chk("rst_adr",   32'(adr_bus), 32'h0);
        chk("rst_dout",  32'(data_bus_out), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);

        // Port 0 write wins first; port 1 read waits.
        reset = 1'b1;
        tick();
        chk("w_a1_gnt", 32'(gnt), 32'h1);
        chk("w_a1_wr",  32'(wr_mem), 32'h1);
        chk("w_a1_rd",  32'(rd_mem), 32'h0);
        chk("w_a1_adr", 32'(adr_bus), 32'h05);
        chk("w_a1_dat", 32'(data_bus_out), 32'hA5);
        chk("w_a1_ack", 32'(ack), 32'h0);
        chk("w_a1_busy", 32'(busy), 32'h1);
        tick();
        chk("w_a2_wr",  32'(wr_mem), 32'h1);
        chk("w_a2_ack", 32'(ack), 32'h0);
        tick();
        chk("w_done_ack", 32'(ack), 32'h1);
        chk("w_done_wr",  32'(wr_mem), 32'h0);
        chk("w_done_gnt", 32'(gnt), 32'h1);
        chk("w_rdata_untouched", 32'(rdata), 32'h0);
        req = 2'b10;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_gnt",  32'(gnt), 32'h0);

        // Port 1 read of the value just written.
        tick();
        chk("r_a1_gnt", 32'(gnt), 32'h2);
        chk("r_a1_rd",  32'(rd_mem), 32'h1);
        chk("r_a1_wr",  32'(wr_mem), 32'h0);
        chk("r_a1_adr", 32'(adr_bus), 32'h05);
        tick();
        chk("r_a2_rd",  32'(rd_mem), 32'h1);
        chk("r_a2_ack", 32'(ack), 32'h0);
        tick();
        chk("r_done_ack",   32'(ack), 32'h2);
        chk("r_done_rdata", 32'(rdata), 32'hA5);
        chk("r_done_rd",    32'(rd_mem), 32'h0);
        req = 2'b00;
        tick();
        chk("r_hold_rdata", 32'(rdata), 32'hA5);
        chk("r_hold_ack",   32'(ack), 32'h0);

        // Continuous requests: port 0 reads 05, port 1 writes 3C to 0A.
        wr = 2'b10; adr0 = 6'h05; adr1 = 6'h0A; wdata1 = 8'h3C;
        req = 2'b11;
        n_both = 0;
        for (int t = 0; t < 4; t++) begin
            exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (ack == 2'b00 && cyc < 20);
            chk($sformatf("rr_ack%0d", t), 32'(ack), 32'(exp_ack));
            chk($sformatf("rr_gap%0d", t), 32'(cyc), (t == 0) ? 32'd3 : 32'd4);
            if (t == 2) chk("rr_rdata_read", 32'(rdata), 32'hA5);
            if (t == 3) chk("rr_rdata_after_wr", 32'(rdata), 32'hA5);
        end
        req = 2'b00;
        tick();
        chk("rr_never_both", 32'(n_both), 32'h0);

        // Reset in the second ACCESS cycle of a port 1 read of 0A.
        wr = 2'b00; req = 2'b10;
        tick();
        chk("ab_a1_rd", 32'(rd_mem), 32'h1);
        tick();
        chk("ab_a2_rd", 32'(rd_mem), 32'h1);
        reset = 1'b0;
        tick();
        chk("ab_rd",    32'(rd_mem), 32'h0);
        chk("ab_ack",   32'(ack), 32'h0);
        chk("ab_rdata", 32'(rdata), 32'h0);
        chk("ab_busy",  32'(busy), 32'h0);
        chk("ab_gnt",   32'(gnt), 32'h0);
        reset = 1'b1;
        tick(); tick(); tick();
        chk("ab_retry_ack",   32'(ack), 32'h2);
        chk("ab_retry_rdata", 32'(rdata), 32'h3C);
        req = 2'b00;
        tick();

        // Zero wait states, port 0 read at the top address.
        req_z = 2'b01;
        tick();
        chk("z_a1_rd",  32'(rd_mem_z), 32'h1);
        chk("z_a1_adr", 32'(adr_bus_z), 32'h3F);
        chk("z_a1_ack", 32'(ack_z), 32'h0);
        chk("z_a1_gnt", 32'(gnt_z), 32'h1);
        tick();
        chk("z_done_rd",    32'(rd_mem_z), 32'h0);
        chk("z_done_ack",   32'(ack_z), 32'h1);
        chk("z_done_rdata", 32'(rdata_z), 32'h9C);
        req_z = 2'b00;
        tick();
        chk("z_idle_busy", 32'(busy_z), 32'h0);
        chk("z_idle_ack",  32'(ack_z), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
